// File: rtl/ad9866clk_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ad9866clk_pkg
// Brief    : Shared state encoding, default timing and counter sizing for the
//            AD9866 PLL power-up/recovery sequencer.
// Revision : 1.0
// ============================================================================
package ad9866clk_pkg;

    typedef enum logic [2:0] {
        ST_RESET_PLL = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } state_e;

    localparam int c_RST_CYCLES_DEF     = 64;
    localparam int c_LOCK_CYCLES_DEF    = 1024;
    localparam int c_TIMEOUT_CYCLES_DEF = 65536;
    localparam int c_MAX_RETRY_DEF      = 7;

    // One counter serves every interval, so size it for the longest one.
    function automatic int CNT_W(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ad9866clk_sync.sv
`default_nettype none
// ============================================================================
// Module   : ad9866clk_sync
// Brief    : Parameterized two-flop synchronizer with async active-low reset.
// Revision : 1.0
// ============================================================================
module ad9866clk_sync
    import ad9866clk_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule
`default_nettype wire

// File: rtl/ad9866clk_seq.sv
`default_nettype none
// ============================================================================
// Module   : ad9866clk_seq
// Brief    : AD9866 clock PLL sequencer: reset, lock wait with timeout, lock
//            qualification, downstream reset release and bounded retries.
// Revision : 1.0
// ============================================================================
module ad9866clk_seq
    import ad9866clk_pkg::*;
#(
    parameter int RST_CYCLES     = c_RST_CYCLES_DEF,
    parameter int LOCK_CYCLES    = c_LOCK_CYCLES_DEF,
    parameter int TIMEOUT_CYCLES = c_TIMEOUT_CYCLES_DEF,
    parameter int MAX_RETRY      = c_MAX_RETRY_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pll_locked,
    input  logic       restart,
    output logic       pll_rst,
    output logic       clk_ok,
    output logic       sys_rst_n,
    output logic       fail,
    output logic [3:0] retries,
    output logic [7:0] loss_cnt,
    output logic [2:0] state
);

    localparam int              c_CW        = CNT_W(RST_CYCLES, LOCK_CYCLES, TIMEOUT_CYCLES);
    localparam logic [c_CW-1:0] c_RST_LAST  = c_CW'(RST_CYCLES - 1);
    localparam logic [c_CW-1:0] c_LOCK_LAST = c_CW'(LOCK_CYCLES - 1);
    localparam logic [c_CW-1:0] c_TO_LAST   = c_CW'(TIMEOUT_CYCLES - 1);
    localparam logic [c_CW-1:0] c_CNT_ONE   = c_CW'(1);
    localparam logic [3:0]      c_MAX_RETRY = 4'(MAX_RETRY);

    logic            lock_s;
    state_e          state_q,   state_d;
    logic [c_CW-1:0] cnt_q;
    logic [3:0]      retries_q, retries_d;
    logic [7:0]      loss_q,    loss_d;
    logic            pll_rst_q, clk_ok_q, sys_rst_n_q, fail_q;
    logic            fail_attempt;
    logic [3:0]      retries_inc;

    ad9866clk_sync #(
        .WIDTH (1)
    ) u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (pll_locked),
        .q_o   (lock_s)
    );

    assign retries_inc = retries_q + 4'd1;

    always_comb begin
        state_d      = state_q;
        retries_d    = retries_q;
        loss_d       = loss_q;
        fail_attempt = 1'b0;
        if (restart) begin
            state_d   = ST_RESET_PLL;
            retries_d = 4'd0;
        end else begin
            case (state_q)
                ST_RESET_PLL: if (cnt_q == c_RST_LAST) state_d = ST_WAIT_LOCK;
                ST_WAIT_LOCK: begin
                    if (lock_s)                  state_d      = ST_STABLE;
                    else if (cnt_q == c_TO_LAST) fail_attempt = 1'b1;
                end
                ST_STABLE: begin
                    if (!lock_s) begin
                        state_d = ST_WAIT_LOCK;
                    end else if (cnt_q == c_LOCK_LAST) begin
                        state_d   = ST_RUN;
                        retries_d = 4'd0;
                    end
                end
                ST_RUN: begin
                    if (!lock_s) begin
                        fail_attempt = 1'b1;
                        if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
                    end
                end
                ST_FAIL: state_d = ST_FAIL;
                default: state_d = ST_RESET_PLL;
            endcase
            if (fail_attempt) begin
                retries_d = retries_inc;
                state_d   = (retries_inc >= c_MAX_RETRY) ? ST_FAIL : ST_RESET_PLL;
            end
        end
    end

    // Outputs decode the next state so they change on the transition edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RESET_PLL;
            cnt_q       <= '0;
            retries_q   <= 4'd0;
            loss_q      <= 8'd0;
            pll_rst_q   <= 1'b1;
            clk_ok_q    <= 1'b0;
            sys_rst_n_q <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= (restart || (state_d != state_q)) ? '0 : cnt_q + c_CNT_ONE;
            retries_q   <= retries_d;
            loss_q      <= loss_d;
            pll_rst_q   <= (state_d == ST_RESET_PLL) || (state_d == ST_FAIL);
            clk_ok_q    <= (state_d == ST_RUN);
            sys_rst_n_q <= (state_d == ST_RUN);
            fail_q      <= (state_d == ST_FAIL);
        end
    end

    assign pll_rst   = pll_rst_q;
    assign clk_ok    = clk_ok_q;
    assign sys_rst_n = sys_rst_n_q;
    assign fail      = fail_q;
    assign retries   = retries_q;
    assign loss_cnt  = loss_q;
    assign state     = state_q;

endmodule
`default_nettype wire
